// File: rtl/m_unit_scheduler_if.sv
// rtl/m_unit_scheduler_if.sv - EX-stage handshake between the pipeline and the RV32M unit
interface m_unit_scheduler_if;
  logic        m_valid;
  logic [2:0]  func3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  rd;
  logic        pipeline_flush;
  logic        m_stall;
  logic        m_done;
  logic [31:0] m_result;
  logic [4:0]  m_rd;
  logic        m_busy;

  modport master (
    output m_valid, func3, op1, op2, rd, pipeline_flush,
    input  m_stall, m_done, m_result, m_rd, m_busy
  );

  modport slave (
    input  m_valid, func3, op1, op2, rd, pipeline_flush,
    output m_stall, m_done, m_result, m_rd, m_busy
  );
endinterface

// File: rtl/m_unit_scheduler.sv
// rtl/m_unit_scheduler.sv - RV32M multiply/divide sequencer; optional M_EARLY_OUT_EN divide early-out
module m_unit_scheduler #(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_STEPS   = 32
) (
  input  logic clk,
  input  logic rst,
  m_unit_scheduler_if.slave mif
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [2:0]  func3_q;
  logic [31:0] op1_q, op2_q;
  logic [4:0]  rd_q;
  logic [63:0] product;
  logic [63:0] acc;          // {remainder, quotient}
  logic        special_q;
  logic [31:0] special_res;

  // Decode of the instruction currently presented in EX
  logic        accept, in_signed, in_a_neg, in_b_neg;
  logic [31:0] in_a_mag, in_b_mag;
  logic        div_zero, div_ovf, early, special;
  logic [31:0] special_val;

  assign accept    = (state == IDLE) && mif.m_valid && !mif.pipeline_flush;
  assign in_signed = !mif.func3[0];
  assign in_a_neg  = in_signed && mif.op1[31];
  assign in_b_neg  = in_signed && mif.op2[31];
  assign in_a_mag  = in_a_neg ? -mif.op1 : mif.op1;
  assign in_b_mag  = in_b_neg ? -mif.op2 : mif.op2;
  assign div_zero  = (mif.op2 == 32'h0);
  assign div_ovf   = in_signed && (mif.op1 == 32'h8000_0000) && (mif.op2 == 32'hFFFF_FFFF);
`ifdef M_EARLY_OUT_EN
  assign early     = (in_b_mag > in_a_mag);
`else
  assign early     = 1'b0;
`endif
  assign special   = div_zero || div_ovf || early;

  // Bypass value for divides that need no iterations
  always_comb begin
    special_val = 32'h0;
    if (div_zero)     special_val = mif.func3[1] ? mif.op1 : 32'hFFFF_FFFF;
    else if (div_ovf) special_val = mif.func3[1] ? 32'h0 : 32'h8000_0000;
    else if (early)   special_val = mif.func3[1] ? mif.op1 : 32'h0;
  end

  // Datapath derived from the latched operation
  logic        a_neg_q, b_neg_q, a_ext, b_ext, rem_ge;
  logic [31:0] b_mag_q, rem_sub, quot_fix, rem_fix, div_res, mul_res, result;
  logic [32:0] rem_sh;
  logic [63:0] a64, b64, div_step;

  assign a_neg_q  = !func3_q[0] && op1_q[31];
  assign b_neg_q  = !func3_q[0] && op2_q[31];
  assign b_mag_q  = b_neg_q ? -op2_q : op2_q;
  // MULHU treats both operands unsigned, MULHSU only rs2
  assign a_ext    = op1_q[31] && !(func3_q[1] && func3_q[0]);
  assign b_ext    = op2_q[31] && !func3_q[1];
  assign a64      = {{32{a_ext}}, op1_q};
  assign b64      = {{32{b_ext}}, op2_q};
  // 33-bit partial remainder so divisors above 2^31 cannot overflow the shift
  assign rem_sh   = acc[63:31];
  assign rem_ge   = (rem_sh >= {1'b0, b_mag_q});
  assign rem_sub  = rem_sh[31:0] - b_mag_q;
  assign div_step = {rem_ge ? rem_sub : rem_sh[31:0], acc[30:0], rem_ge};
  assign quot_fix = (a_neg_q ^ b_neg_q) ? -acc[31:0] : acc[31:0];
  assign rem_fix  = a_neg_q ? -acc[63:32] : acc[63:32];
  assign div_res  = func3_q[1] ? rem_fix : quot_fix;
  assign mul_res  = (func3_q[1:0] == 2'b00) ? product[31:0] : product[63:32];
  assign result   = special_q ? special_res : (func3_q[2] ? div_res : mul_res);

  // State register plus operand latch, product register and divider iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      func3_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      product     <= '0;
      acc         <= '0;
      special_q   <= 1'b0;
      special_res <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          func3_q     <= mif.func3;
          op1_q       <= mif.op1;
          op2_q       <= mif.op2;
          rd_q        <= mif.rd;
          special_q   <= mif.func3[2] && special;
          special_res <= special_val;
          acc         <= {32'h0, in_a_mag};
          cnt         <= mif.func3[2] ? 6'(DIV_STEPS) : 6'(MUL_LATENCY - 1);
        end
        MUL: begin
          product <= a64 * b64;
          if (cnt != 6'd0) cnt <= cnt - 6'd1;
        end
        DIV: begin
          acc <= div_step;
          if (cnt != 6'd0) cnt <= cnt - 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Next state and pipeline-facing outputs; flush overrides everything
  always_comb begin
    state_nxt    = state;
    mif.m_busy   = (state == MUL) || (state == DIV);
    mif.m_done   = (state == DONE) && !mif.pipeline_flush;
    mif.m_stall  = !mif.pipeline_flush && (((state == IDLE) && mif.m_valid) || mif.m_busy);
    mif.m_result = mif.m_done ? result : 32'h0;
    mif.m_rd     = mif.m_done ? rd_q : 5'h0;
    if (mif.pipeline_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (mif.m_valid) state_nxt = !mif.func3[2] ? MUL : (special ? DONE : DIV);
        MUL:  if (cnt == 6'd0) state_nxt = DONE;
        DIV:  if (cnt == 6'd1) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_unit_scheduler.sv
// tb/tb_m_unit_scheduler.sv - directed bench for m_unit_scheduler
module tb_m_unit_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

`ifdef M_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  m_unit_scheduler_if mif();

  m_unit_scheduler #(.MUL_LATENCY(2), .DIV_STEPS(32)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; drives the op, holds m_valid through DONE, returns at posedge+1 after DONE
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp_res, input int exp_lat);
    int n = 0;
    int stalls = 0;
    int busys = 0;
    bit seen = 0;
    logic [31:0] res = 0;
    logic [4:0]  rdo = 0;
    logic        stall_done = 1'b1;
    mif.pipeline_flush = 1'b0;
    mif.m_valid = 1'b1;
    mif.func3 = f3;
    mif.op1 = a;
    mif.op2 = b;
    mif.rd = r;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (mif.m_done) begin
        seen = 1;
        res = mif.m_result;
        rdo = mif.m_rd;
        stall_done = mif.m_stall;
      end else begin
        if (mif.m_stall) stalls++;
        if (mif.m_busy) busys++;
        n++;
      end
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_rd"}, {27'h0, rdo}, {27'h0, r});
    check({tag, "_stall_cycles"}, stalls, exp_lat);
    check({tag, "_busy_cycles"}, busys, exp_lat - 1);
    check({tag, "_stall_in_done"}, {31'h0, stall_done}, 32'h0);
    @(posedge clk);
    #1;
    mif.m_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int dn;
    rst = 1'b1;
    mif.m_valid = 1'b0;
    mif.func3 = 3'b000;
    mif.op1 = 32'h0;
    mif.op2 = 32'h0;
    mif.rd = 5'h0;
    mif.pipeline_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", {31'h0, mif.m_done}, 32'h0);
    check("rst_result", mif.m_result, 32'h0);
    check("rst_rd", {27'h0, mif.m_rd}, 32'h0);
    check("rst_busy", {31'h0, mif.m_busy}, 32'h0);
    check("rst_stall", {31'h0, mif.m_stall}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("mul",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 3);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 3);
    run_op("mulh",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 3);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 3);
    run_op("div",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, 33);
    run_op("rem",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33);
    run_op("div_nd",   3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 5'd9,  32'hFFFF_FFFD, 33);
    run_op("rem_nd",   3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 5'd10, 32'h0000_0001, 33);
    run_op("divu",     3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        33);
    run_op("remu",     3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         33);
    run_op("divu_big", 3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 5'd13, 32'h0000_0001, 33);
    run_op("remu_big", 3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 5'd14, 32'h7FFF_FFFE, 33);
    run_op("divu_z",   3'b101, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1);
    run_op("remu_z",   3'b111, 32'd5,         32'd0,         5'd16, 32'd5,         1);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 1);

    // Flush in cycle 10 of a DIVU, then a MUL accepted in cycle 11
    dn = 0;
    mif.m_valid = 1'b1;
    mif.func3 = 3'b101;
    mif.op1 = 32'd100;
    mif.op2 = 32'd7;
    mif.rd = 5'd20;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mif.m_done) dn++;
      @(posedge clk);
      #1;
    end
    mif.pipeline_flush = 1'b1;
    @(negedge clk);
    check("flush_stall", {31'h0, mif.m_stall}, 32'h0);
    check("flush_done", {31'h0, mif.m_done}, 32'h0);
    check("flush_no_early_done", dn, 0);
    @(posedge clk);
    #1;
    run_op("mul_after_flush", 3'b000, 32'd6, 32'd9, 5'd21, 32'd54, 3);

    // Reset in cycle 5 of a DIV
    dn = 0;
    mif.m_valid = 1'b1;
    mif.func3 = 3'b100;
    mif.op1 = 32'hFFFF_FFF9;
    mif.op2 = 32'd2;
    mif.rd = 5'd22;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mif.m_done) dn++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mif.m_valid = 1'b0;
    @(negedge clk);
    check("midrst_done", {31'h0, mif.m_done}, 32'h0);
    check("midrst_result", mif.m_result, 32'h0);
    check("midrst_rd", {27'h0, mif.m_rd}, 32'h0);
    check("midrst_busy", {31'h0, mif.m_busy}, 32'h0);
    check("midrst_stall", {31'h0, mif.m_stall}, 32'h0);
    check("midrst_no_done", dn, 0);
    @(posedge clk);
    #1;
    run_op("divu_small", 3'b101, 32'd3, 32'd10, 5'd23, 32'd0, EARLY_LAT);
    run_op("remu_small", 3'b111, 32'd3, 32'd10, 5'd24, 32'd3, EARLY_LAT);
    run_op("rem_small_neg", 3'b110, 32'hFFFF_FFFD, 32'd10, 5'd25, 32'hFFFF_FFFD, EARLY_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/m_unit_scheduler.md
Name: m_unit_scheduler

Overview:
Sequences the multi-cycle RV32M multiply/divide unit that sits beside the ALU in the execute stage. It takes forwarded operands (op1_selected/op2_selected) when an M-type instruction is in EX. It stalls the pipeline while the operation runs, then presents a one-cycle result for the EX/MEM register. Multiplies use a fixed-latency counter over a registered product. Divides use an iterative 32-step restoring divider with sign fix-up and special-case bypass.

Parameters:
MUL_LATENCY, 2, cycles from accept to result for MUL/MULH/MULHSU/MULHU; legal range 1..8
DIV_STEPS, 32, restoring-divider iterations; fixed at 32 for RV32, exposed only for bench shortening

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
m_valid  in  1  M-type instruction in EX (opcode 0110011, func7 0000001)
func3  in  3  RV32M operation select (000 MUL … 111 REMU)
op1  in  32  forwarded rs1 value
op2  in  32  forwarded rs2 value
rd  in  5  destination register
pipeline_flush  in  1  kill in-flight operation
m_stall  out  1  hold IF/ID/EX; combinational
m_done  out  1  result valid, one cycle
m_result  out  32  result (valid only when m_done=1)
m_rd  out  5  destination (0 when m_done=0)
m_busy  out  1  state is MUL or DIV

Behaviour:
- Reset: rst sampled at posedge → state IDLE; m_done=0, m_result=0, m_rd=0, m_busy=0. All internal counters and accumulators are cleared. Reset mid-operation abandons the operation with no m_done.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - m_valid=1 and pipeline_flush=0 → latch func3, op1, op2, rd.
  - func3[2]=0 → MUL; load counter with MUL_LATENCY-1.
  - func3[2]=1 and a special case applies → DONE directly.
  - Otherwise → DIV; load counter with DIV_STEPS.
- MUL: the 64-bit product is registered the cycle after accept.
  - Operands are sign-extended to 33 bits per func3: MUL/MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned×unsigned.
  - Counter decrements each cycle; at 0 → DONE.
  - Result is the low 32 bits for MUL, high 32 bits otherwise.
- DIV: operates on magnitudes for DIV/REM, raw values for DIVU/REMU.
  - Each cycle performs one shift-subtract step on a 64-bit {remainder,quotient} register.
  - After DIV_STEPS steps → DONE.
  - Quotient is negated if the operand signs differ (signed ops only). Remainder takes the sign of the dividend.
- Special cases (resolved in IDLE, no iterations):
  - Divisor 0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU remainder = op1.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- DONE: m_done=1, m_result valid, m_rd=latched rd, m_stall=0. → IDLE next cycle.
  - A new m_valid in the DONE cycle is ignored: it belongs to the same stalled instruction now leaving EX.
- m_stall = (IDLE & m_valid & ~pipeline_flush) | MUL | DIV.
- Latency (accept edge = end of cycle 0; m_done high in cycle N):
  - Multiply: N = MUL_LATENCY+1.
  - Normal divide: N = DIV_STEPS+1 = 33.
  - Special case: N = 1.
- pipeline_flush=1 in any state → IDLE at next edge. m_done is forced 0 in that cycle and m_stall drops combinationally. Flush overrides m_valid.
- Simultaneous rst and flush: rst wins (same result).

Optional Feature:
M_EARLY_OUT_EN:
- Defined: in IDLE, an unsigned/magnitude divisor greater than the dividend → DONE directly (quotient 0, remainder = dividend with sign rule), latency 1.
- Undefined: such divides take the full 33 cycles.
- The result value is identical either way.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD (−3), MUL_LATENCY=2 → m_stall high cycles 0–2; m_done in cycle 3 with m_result=0xFFFFFFEB.
- MULHU op1=op2=0xFFFFFFFF → m_result=0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU op1=0xFFFFFFFF, op2=2 → 0xFFFFFFFF.
- DIV op1=0xFFFFFFF9 (−7), op2=2 → m_done in cycle 33, m_result=0xFFFFFFFD. REM same operands → 0xFFFFFFFF.
- DIVU 5/0 → 0xFFFFFFFF in cycle 1. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000 in cycle 1.
- DIVU 100/7 with pipeline_flush in cycle 10 → m_stall low in cycle 10, no m_done, IDLE in cycle 11. A new MUL accepted in cycle 11 completes normally.
- rst in cycle 5 of a DIV → all outputs 0 next cycle, no m_done. A subsequent DIVU 3/10 returns 0 in cycle 1 with M_EARLY_OUT_EN, in cycle 33 without.
